// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters.
// Owns the icc register that feeds the ALU carry-in; one operation in flight at a time.
module alu_arbiter #(
    parameter int DATA_W    = 32,
    parameter bit FIRST_REQ = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic [3:0]        req0_op,
    input  logic              req0_setcc,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    input  logic [3:0]        req1_op,
    input  logic              req1_setcc,
    output logic              rsp0_valid,
    input  logic              rsp0_ready,
    output logic [DATA_W-1:0] rsp0_y,
    output logic [3:0]        rsp0_flags,
    output logic              rsp1_valid,
    input  logic              rsp1_ready,
    output logic [DATA_W-1:0] rsp1_y,
    output logic [3:0]        rsp1_flags,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic              alu_cin,
    output logic [3:0]        alu_opcode,
    input  logic [DATA_W-1:0] alu_y,
    input  logic [3:0]        alu_flags,
    output logic [3:0]        icc
);

    generate
        if (DATA_W != 32) begin : g_bad_width
            $error("alu_arbiter: only DATA_W=32 is supported");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t            state_reg;
    logic [DATA_W-1:0] a_reg, b_reg, result_reg;
    logic [3:0]        op_reg, flags_reg, icc_reg;
    logic              setcc_reg, owner_reg, last_grant_reg, cin_reg;

    logic [1:0]        req_valid_w, req_ready_w, rsp_valid_w, rsp_ready_w;
    logic              grant_w;
    logic              accept_w;
    logic              op_has_flags_w;

    assign req_valid_w = {req1_valid, req0_valid};
    assign rsp_ready_w = {rsp1_ready, rsp0_ready};

    // Contested requests go to whoever did not win last time.
    always_comb begin
        grant_w = last_grant_reg;
        if (req_valid_w == 2'b11)
            grant_w = ~last_grant_reg;
        else if (req_valid_w[0])
            grant_w = 1'b0;
        else if (req_valid_w[1])
            grant_w = 1'b1;
    end

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_port
            assign req_ready_w[gi] = (state_reg == IDLE) && (grant_w == 1'(gi)) && req_valid_w[gi];
            assign rsp_valid_w[gi] = (state_reg == RESP) && (owner_reg == 1'(gi));
        end
    endgenerate

    assign accept_w       = |req_ready_w;
    // Opcodes 1010..1111 are shifts/moves and produce no meaningful flags.
    assign op_has_flags_w = (op_reg <= 4'b1001);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            a_reg          <= '0;
            b_reg          <= '0;
            op_reg         <= '0;
            setcc_reg      <= 1'b0;
            owner_reg      <= 1'b0;
            cin_reg        <= 1'b0;
            last_grant_reg <= ~FIRST_REQ;
            result_reg     <= '0;
            flags_reg      <= '0;
            icc_reg        <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (accept_w) begin
                        a_reg          <= grant_w ? req1_a : req0_a;
                        b_reg          <= grant_w ? req1_b : req0_b;
                        op_reg         <= grant_w ? req1_op : req0_op;
                        setcc_reg      <= grant_w ? req1_setcc : req0_setcc;
                        owner_reg      <= grant_w;
                        last_grant_reg <= grant_w;
                        // icc cannot change between accept and EXEC, so latch C now.
                        cin_reg        <= icc_reg[1];
                        state_reg      <= EXEC;
                    end
                end
                EXEC: begin
                    result_reg <= alu_y;
                    flags_reg  <= op_has_flags_w ? alu_flags : 4'b0000;
                    if (setcc_reg && op_has_flags_w)
                        icc_reg <= alu_flags;
                    state_reg  <= RESP;
                end
                RESP: begin
                    if (rsp_ready_w[owner_reg])
                        state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign req0_ready = req_ready_w[0];
    assign req1_ready = req_ready_w[1];
    assign rsp0_valid = rsp_valid_w[0];
    assign rsp1_valid = rsp_valid_w[1];
    assign rsp0_y     = result_reg;
    assign rsp1_y     = result_reg;
    assign rsp0_flags = flags_reg;
    assign rsp1_flags = flags_reg;
    assign alu_a      = a_reg;
    assign alu_b      = b_reg;
    assign alu_opcode = op_reg;
    assign alu_cin    = cin_reg;
    assign icc        = icc_reg;

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: directed requests push expected results,
// a negedge monitor pops and compares on every response handshake.
module tb_alu_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  req_valid = 2'b00;
    logic [1:0]  rsp_ready = 2'b11;
    logic [31:0] req_a [2];
    logic [31:0] req_b [2];
    logic [3:0]  req_op [2];
    logic [1:0]  req_setcc = 2'b00;
    logic        req0_ready, req1_ready, rsp0_valid, rsp1_valid, alu_cin;
    logic [31:0] rsp0_y, rsp1_y, alu_a, alu_b, alu_y;
    logic [3:0]  rsp0_flags, rsp1_flags, alu_opcode, alu_flags, icc;
    logic [1:0]  rdy, rsp_valid;

    int total = 0;
    int bad = 0;
    logic [35:0] q0[$];
    logic [35:0] q1[$];
    int grant_log[$];

    always #5 clk = ~clk;

    assign rdy       = {req1_ready, req0_ready};
    assign rsp_valid = {rsp1_valid, rsp0_valid};

    alu_arbiter #(.DATA_W(32), .FIRST_REQ(1'b0)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req_valid[0]), .req0_ready(req0_ready), .req0_a(req_a[0]), .req0_b(req_b[0]),
        .req0_op(req_op[0]), .req0_setcc(req_setcc[0]),
        .req1_valid(req_valid[1]), .req1_ready(req1_ready), .req1_a(req_a[1]), .req1_b(req_b[1]),
        .req1_op(req_op[1]), .req1_setcc(req_setcc[1]),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp_ready[0]), .rsp0_y(rsp0_y), .rsp0_flags(rsp0_flags),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp_ready[1]), .rsp1_y(rsp1_y), .rsp1_flags(rsp1_flags),
        .alu_a(alu_a), .alu_b(alu_b), .alu_cin(alu_cin), .alu_opcode(alu_opcode),
        .alu_y(alu_y), .alu_flags(alu_flags), .icc(icc)
    );

    // Combinational ALU model: add/addx/sub/subx, logic ops, shifts and moves.
    always_comb begin
        logic [32:0] s;
        logic        c, v;
        s = '0;
        c = 1'b0;
        v = 1'b0;
        case (alu_opcode)
            4'b0000, 4'b0001: begin
                s = {1'b0, alu_a} + {1'b0, alu_b} + {32'd0, (alu_opcode[0] & alu_cin)};
                c = s[32];
                v = (alu_a[31] == alu_b[31]) && (s[31] != alu_a[31]);
            end
            4'b0010, 4'b0011: begin
                s = {1'b0, alu_a} - {1'b0, alu_b} - {32'd0, (alu_opcode[0] & alu_cin)};
                c = s[32];
                v = (alu_a[31] != alu_b[31]) && (s[31] != alu_a[31]);
            end
            4'b0100: s = {1'b0, alu_a & alu_b};
            4'b0101: s = {1'b0, alu_a | alu_b};
            4'b0110: s = {1'b0, alu_a ^ alu_b};
            4'b0111: s = {1'b0, alu_a & ~alu_b};
            4'b1000: s = {1'b0, alu_a | ~alu_b};
            4'b1001: s = {1'b0, ~(alu_a ^ alu_b)};
            4'b1010: s = {1'b0, alu_a << alu_b[4:0]};
            4'b1011: s = {1'b0, alu_a >> alu_b[4:0]};
            4'b1100: s = {1'b0, $signed(alu_a) >>> alu_b[4:0]};
            4'b1101: s = {1'b0, alu_a};
            4'b1110: s = {1'b0, alu_b};
            default: s = {1'b0, ~alu_b};
        endcase
        alu_y     = s[31:0];
        alu_flags = {(s[31:0] == 32'd0), s[31], c, v};
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic check_rsp(input int n, input logic [31:0] y, input logic [3:0] f);
        logic [35:0] e;
        if ((n == 0 && q0.size() == 0) || (n == 1 && q1.size() == 0)) begin
            total++;
            bad++;
            $display("FAIL rsp%0d_unexpected: got y=%h flags=%b expected no response", n, y, f);
        end else begin
            e = (n == 0) ? q0.pop_front() : q1.pop_front();
            $display("rsp%0d y=%h flags=%b (expect y=%h flags=%b)", n, y, f, e[35:4], e[3:0]);
            chk($sformatf("rsp%0d_y", n), y, e[35:4]);
            chk($sformatf("rsp%0d_flags", n), {28'd0, f}, {28'd0, e[3:0]});
        end
    endtask

    // Monitor: only one response may be valid at a time; compare on handshake.
    always @(negedge clk) begin
        if (rst_n) begin
            if (rsp_valid != 2'b00)
                chk("rsp_onehot", {30'd0, rsp_valid == 2'b11}, 32'd0);
            if (rsp0_valid && rsp_ready[0]) check_rsp(0, rsp0_y, rsp0_flags);
            if (rsp1_valid && rsp_ready[1]) check_rsp(1, rsp1_y, rsp1_flags);
        end
    end

    task automatic present(input int n, input logic [31:0] a, input logic [31:0] b,
                           input logic [3:0] op, input logic sc,
                           input logic [31:0] ey, input logic [3:0] ef);
        if (n == 0) q0.push_back({ey, ef});
        else        q1.push_back({ey, ef});
        req_a[n]     = a;
        req_b[n]     = b;
        req_op[n]    = op;
        req_setcc[n] = sc;
        req_valid[n] = 1'b1;
    endtask

    // Returns on the negedge after the accepting edge (DUT then in EXEC).
    task automatic wait_accept(input int n);
        bit done = 1'b0;
        for (int k = 0; k < 60 && !done; k++) begin
            #1;
            if (rdy[n]) begin
                @(posedge clk);
                grant_log.push_back(n);
                $display("req%0d accepted a=%h b=%h op=%b", n, req_a[n], req_b[n], req_op[n]);
                @(negedge clk);
                req_valid[n] = 1'b0;
                done = 1'b1;
            end else begin
                @(negedge clk);
            end
        end
        if (!done) begin
            total++;
            bad++;
            $display("FAIL req%0d_accept_timeout: got no ready expected ready within 60 cycles", n);
            req_valid[n] = 1'b0;
        end
    endtask

    task automatic issue(input int n, input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] op, input logic sc,
                         input logic [31:0] ey, input logic [3:0] ef);
        present(n, a, b, op, sc, ey, ef);
        wait_accept(n);
    endtask

    task automatic cycles(input int k);
        repeat (k) @(negedge clk);
    endtask

    task automatic drain;
        for (int k = 0; k < 40 && (q0.size() + q1.size()) != 0; k++) @(negedge clk);
        chk("drain_pending", q0.size() + q1.size(), 32'd0);
    endtask

    task automatic rst_pulse;
        @(negedge clk);
        rst_n     = 1'b0;
        req_valid = 2'b00;
        q0.delete();
        q1.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200000");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 2; i++) begin
            req_a[i]  = '0;
            req_b[i]  = '0;
            req_op[i] = '0;
        end
        #1;
        chk("reset_rsp0_valid", {31'd0, rsp0_valid}, 32'd0);
        chk("reset_rsp1_valid", {31'd0, rsp1_valid}, 32'd0);
        chk("reset_icc", {28'd0, icc}, 32'd0);
        chk("reset_alu_a", alu_a, 32'd0);
        chk("reset_alu_cin", {31'd0, alu_cin}, 32'd0);
        chk("reset_rsp0_y", rsp0_y, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic add with latency check.
        issue(0, 32'd5, 32'd7, 4'b0000, 1'b1, 32'd12, 4'b0000);
        chk("lat_exec_rsp0_valid", {31'd0, rsp0_valid}, 32'd0);
        @(negedge clk);
        chk("lat_resp_rsp0_valid", {31'd0, rsp0_valid}, 32'd1);
        chk("lat_resp_rsp1_valid", {31'd0, rsp1_valid}, 32'd0);
        drain();
        chk("icc_after_add", {28'd0, icc}, 32'd0);

        // Carry out sets icc, next addx consumes it.
        issue(1, 32'hFFFF_FFFF, 32'd1, 4'b0000, 1'b1, 32'd0, 4'b1010);
        cycles(3);
        chk("icc_after_carry", {28'd0, icc}, 32'b1010);
        issue(1, 32'd0, 32'd0, 4'b0001, 1'b0, 32'd1, 4'b0000);
        chk("addx_cin", {31'd0, alu_cin}, 32'd1);
        drain();

        // Shift with setcc must not touch icc.
        issue(0, 32'd1, 32'd4, 4'b1010, 1'b1, 32'd16, 4'b0000);
        drain();
        chk("icc_after_shift", {28'd0, icc}, 32'b1010);

        // Back-pressure on rsp0 while req1 waits.
        rsp_ready[0] = 1'b0;
        issue(0, 32'd3, 32'd5, 4'b0110, 1'b0, 32'd6, 4'b0000);
        present(1, 32'd10, 32'd20, 4'b0000, 1'b0, 32'd30, 4'b0000);
        @(negedge clk);
        for (int k = 0; k < 10; k++) begin
            chk("bp_rsp0_valid", {31'd0, rsp0_valid}, 32'd1);
            chk("bp_rsp0_y", rsp0_y, 32'd6);
            chk("bp_req1_ready", {31'd0, req1_ready}, 32'd0);
            @(negedge clk);
        end
        rsp_ready[0] = 1'b1;
        wait_accept(1);
        drain();

        // Both requesters always valid: grants alternate from FIRST_REQ.
        rst_pulse();
        grant_log.delete();
        fork
            for (int i = 1; i <= 10; i++)
                issue(0, 32'(i), 32'd0, 4'b0000, 1'b0, 32'(i), 4'b0000);
            for (int i = 1; i <= 10; i++)
                issue(1, 32'(i), 32'd1000, 4'b0000, 1'b0, 32'(i + 1000), 4'b0000);
        join
        drain();
        chk("grant_count", grant_log.size(), 32'd20);
        for (int i = 0; i < grant_log.size(); i++)
            chk($sformatf("grant_order[%0d]", i), 32'(grant_log[i]), 32'(i % 2));

        // Reset asserted during EXEC drops the op.
        issue(0, 32'd1, 32'd2, 4'b0010, 1'b1, 32'hFFFF_FFFF, 4'b0110);
        drain();
        chk("icc_after_sub", {28'd0, icc}, 32'b0110);
        issue(0, 32'd9, 32'd9, 4'b0000, 1'b0, 32'd18, 4'b0000);
        rst_n = 1'b0;
        q0.delete();
        #1;
        chk("rst_exec_rsp0_valid", {31'd0, rsp0_valid}, 32'd0);
        chk("rst_exec_rsp0_y", rsp0_y, 32'd0);
        chk("rst_exec_icc", {28'd0, icc}, 32'd0);
        chk("rst_exec_alu_a", alu_a, 32'd0);
        cycles(2);
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("rst_no_rsp0", {31'd0, rsp0_valid}, 32'd0);
        end
        issue(0, 32'd2, 32'd3, 4'b0000, 1'b0, 32'd5, 4'b0000);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
